// File: rtl/seg_dynamic.sv
// seg_dynamic: six-digit multiplexed 7-segment driver.
// Clamps the binary input to 999_999, converts it to BCD with a sequential
// shift-add-3 engine, and scans the committed digits one per CNT_MAX+1 clocks
// with leading-zero blanking, decimal points and an optional minus sign.
//
// Conversion FSM states:
//   state    | meaning
//   ST_IDLE  | waiting; loads a new value (load cycle) when a conversion is due
//   ST_SHIFT | shifting one bit per cycle, commits to display on the 20th shift
module seg_dynamic #(
  parameter int CNT_MAX = 49_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        sign,
  input  logic        seg_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  localparam int              CW       = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]   CNT_TOP  = CW'(CNT_MAX);
  localparam logic [19:0]     DATA_MAX = 20'd999_999;

  typedef enum logic [0:0] {ST_IDLE, ST_SHIFT} conv_st_e;

  conv_st_e     st_q;
  logic         first_q;
  logic [19:0]  last_q;
  logic [19:0]  shift_q;
  logic [23:0]  bcd_q;
  logic [23:0]  disp_q;
  logic [4:0]   bit_cnt_q;

  logic [19:0]  data_c;
  logic         conv_start;
  logic [23:0]  bcd_adj;
  logic [23:0]  bcd_d;

  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;

  logic [3:0]   cur_dig;
  logic [2:0]   top_m;
  logic [6:0]   code7;
  logic [7:0]   seg_d;

  // Clamp and decide whether the committed value is stale
  always_comb begin
    data_c     = (data > DATA_MAX) ? DATA_MAX : data;
    conv_start = first_q || (data_c != last_q);
  end

  // Add 3 to every BCD nibble >= 5, then shift in the next binary bit
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_d = {bcd_adj[22:0], shift_q[19]};
  end

  // Conversion FSM: one load cycle, then 20 shift cycles; commit on the last
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st_q      <= ST_IDLE;
      first_q   <= 1'b1;
      last_q    <= '0;
      shift_q   <= '0;
      bcd_q     <= '0;
      disp_q    <= '0;
      bit_cnt_q <= '0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (conv_start) begin
            first_q   <= 1'b0;
            last_q    <= data_c;
            shift_q   <= data_c;
            bcd_q     <= '0;
            bit_cnt_q <= 5'd19;
            st_q      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_q   <= bcd_d;
          shift_q <= {shift_q[18:0], 1'b0};
          if (bit_cnt_q == 5'd0) begin
            disp_q <= bcd_d;
            st_q   <= ST_IDLE;
          end else begin
            bit_cnt_q <= bit_cnt_q - 5'd1;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  // Scan timer and digit index; keeps running while the display is blanked
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CNT_TOP) begin
      cnt_q <= '0;
      idx_q <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Highest digit that must be shown: last nonzero digit or lit decimal point
  always_comb begin
    top_m = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if ((disp_q[4*i +: 4] != 4'd0) || point[i]) begin
        top_m = 3'(i);
      end
    end
  end

  // Pick the digit under scan and encode it (active-low, dp handled separately)
  always_comb begin
    case (idx_q)
      3'd0:    cur_dig = disp_q[3:0];
      3'd1:    cur_dig = disp_q[7:4];
      3'd2:    cur_dig = disp_q[11:8];
      3'd3:    cur_dig = disp_q[15:12];
      3'd4:    cur_dig = disp_q[19:16];
      3'd5:    cur_dig = disp_q[23:20];
      default: cur_dig = 4'd0;
    endcase

    code7 = 7'h7F;
    if (idx_q <= top_m) begin
      case (cur_dig)
        4'd0:    code7 = 7'h40;
        4'd1:    code7 = 7'h79;
        4'd2:    code7 = 7'h24;
        4'd3:    code7 = 7'h30;
        4'd4:    code7 = 7'h19;
        4'd5:    code7 = 7'h12;
        4'd6:    code7 = 7'h02;
        4'd7:    code7 = 7'h78;
        4'd8:    code7 = 7'h00;
        4'd9:    code7 = 7'h10;
        default: code7 = 7'h7F;
      endcase
    end else if (sign && (top_m != 3'd5) && (idx_q == top_m + 3'd1)) begin
      code7 = 7'h3F;
    end

    seg_d = {~point[idx_q], code7};
  end

  // Registered digit select and segment drive
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel <= 6'b000000;
      seg <= 8'hFF;
    end else if (seg_en) begin
      sel <= 6'b000001 << idx_q;
      seg <= seg_d;
    end else begin
      sel <= 6'b000000;
      seg <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg_dynamic.sv
// Bench for seg_dynamic with a 10-clock digit period.
module tb_seg_dynamic;

  localparam int CNT_MAX = 9;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [19:0] data      = '0;
  logic [5:0]  point     = '0;
  logic        sign      = 1'b0;
  logic        seg_en    = 1'b1;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         dig;
    logic [5:0] sel;
    logic [7:0] seg;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] commits[$];
  logic [23:0] prev_disp;
  bit          mon_en = 1'b0;

  seg_dynamic #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .data     (data),
    .point    (point),
    .sign     (sign),
    .seg_en   (seg_en),
    .sel      (sel),
    .seg      (seg)
  );

  always #10 sys_clk = ~sys_clk;

  // Record every change of the committed display value
  always @(negedge sys_clk) begin
    if (mon_en && (dut.disp_q !== prev_disp)) commits.push_back(dut.disp_q);
    prev_disp = dut.disp_q;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dec7(input int x);
    case (x)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] model_seg(input int k, input int v, input logic [5:0] p, input logic s);
    int d[6];
    int m;
    logic [7:0] c;
    if (v > 999999) v = 999999;
    for (int i = 0; i < 6; i++) begin
      d[i] = v % 10;
      v    = v / 10;
    end
    m = 0;
    for (int i = 0; i < 6; i++) if (d[i] != 0 || p[i]) m = i;
    if (k <= m)                          c = dec7(d[k]);
    else if (s && m < 5 && k == m + 1)   c = 8'hBF;
    else                                 c = 8'hFF;
    if (p[k]) c[7] = 1'b0;
    return c;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic push_display();
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      e.dig = k;
      e.sel = 6'(1 << k);
      e.seg = model_seg(k, int'(data), point, sign);
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    exp_t e;
    bit   found;
    while (sb.size() > 0) begin
      e     = sb.pop_front();
      found = 1'b0;
      for (int t = 0; t < 200; t++) begin
        @(negedge sys_clk);
        if (sel == e.sel) begin
          found = 1'b1;
          break;
        end
      end
      chk($sformatf("%s_wait_d%0d", tag, e.dig), 32'(found), 32'd1);
      if (found) chk($sformatf("%s_seg_d%0d", tag, e.dig), 32'(seg), 32'(e.seg));
    end
  endtask

  task automatic wait_sel(input logic [5:0] want, output bit found);
    found = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge sys_clk);
      if (sel == want) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  function automatic int sel_idx(input logic [5:0] s);
    for (int i = 0; i < 6; i++) if (s == 6'(1 << i)) return i;
    return -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit         found;
    int         n;
    int         lo, ln, step;
    logic [5:0] old_sel;

    // Reset state
    data = 20'd123456;
    cycles(3);
    chk("rst_sel", 32'(sel), 32'h00);
    chk("rst_seg", 32'(seg), 32'hFF);
    sys_rst_n = 1'b1;

    // 123456 scan and digit period
    cycles(30);
    push_display();
    drain("r26");
    wait_sel(6'h20, found);
    chk("period_sync0", 32'(found), 32'd1);
    wait_sel(6'h01, found);
    chk("period_sync1", 32'(found), 32'd1);
    n = 0;
    while (sel == 6'h01 && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    chk("period_len", 32'(n), 32'd10);
    chk("period_next", 32'(sel), 32'h02);

    // Minus sign after two digits
    data = 20'd42; sign = 1'b1; point = 6'b000000;
    cycles(30);
    push_display();
    drain("r27");

    // Decimal point extends the shown digits
    data = 20'd5; sign = 1'b0; point = 6'b000100;
    cycles(30);
    push_display();
    drain("r28");

    // Clamp to 999999; sign suppressed when all six digits are in use
    data = 20'd1_048_575; sign = 1'b1; point = 6'b000000;
    cycles(30);
    push_display();
    drain("r29a");

    // Data changes mid-conversion: 7 commits, then 8
    data = 20'd0; sign = 1'b0;
    cycles(30);
    commits.delete();
    mon_en = 1'b1;
    data = 20'd7;
    cycles(3);
    data = 20'd8;
    cycles(60);
    mon_en = 1'b0;
    chk("commit_count", 32'(commits.size()), 32'd2);
    if (commits.size() >= 1) chk("commit_first", 32'(commits[0]), 32'h000007);
    if (commits.size() >= 2) chk("commit_second", 32'(commits[1]), 32'h000008);
    push_display();
    drain("r29b");

    // Blank for 25 clocks, scan keeps running underneath
    @(negedge sys_clk);
    old_sel = sel;
    seg_en  = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge sys_clk);
      chk($sformatf("dis_sel_%0d", i), 32'(sel), 32'h00);
      chk($sformatf("dis_seg_%0d", i), 32'(seg), 32'hFF);
    end
    seg_en = 1'b1;
    @(negedge sys_clk);
    lo   = sel_idx(old_sel);
    ln   = sel_idx(sel);
    step = (ln - lo + 6) % 6;
    chk("reen_onehot", 32'((lo >= 0) && (ln >= 0)), 32'd1);
    chk("reen_step", 32'((step == 2) || (step == 3)), 32'd1);

    // Asynchronous reset in the middle of a conversion
    data = 20'd654321;
    cycles(5);
    #3;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'(sel), 32'h00);
    chk("arst_seg", 32'(seg), 32'hFF);
    cycles(3);
    chk("arst_hold_sel", 32'(sel), 32'h00);
    chk("arst_hold_seg", 32'(seg), 32'hFF);
    commits.delete();
    mon_en    = 1'b1;
    sys_rst_n = 1'b1;
    cycles(40);
    mon_en = 1'b0;
    chk("arst_commit_seen", 32'(commits.size() >= 1), 32'd1);
    if (commits.size() >= 1) chk("arst_commit_val", 32'(commits[0]), 32'h654321);
    push_display();
    drain("r31");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
